instr_fetch_unit: RTL and testbench
===================================

Name: instr_fetch_unit

Overview:
Instruction fetch stage of the RISC16bit core. It sits directly upstream of Memory256x16: it drives the memory address and read controls, and it captures returning 16-bit words into a 2-entry instruction buffer. It presents those words to the decode stage over a valid/ready handshake. It supports PC redirect (branch/jump), halt, and full-rate streaming despite the memory's 1-cycle read latency.

Parameters:
ADDR_W, 8, memory address width / PC width (256 words)
DATA_W, 16, instruction word width
RESET_PC, 8'h00, PC value loaded on reset

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous, active-low reset
mem_addr  out  ADDR_W  address to Memory256x16 addr; registered, equals fetch PC
mem_we  out  1  write enable to memory; constant 0
mem_din  out  DATA_W  write data to memory; constant 0
mem_dout  in  DATA_W  memory read data; valid the cycle after mem_addr is sampled
redirect_valid  in  1  load new PC and flush (branch/jump taken)
redirect_pc  in  ADDR_W  redirect target
halt  in  1  stop issuing new fetches while high
ir_valid  out  1  buffer head holds a valid instruction
ir_ready  in  1  decode accepts head this cycle
ir_data  out  DATA_W  instruction at buffer head
ir_pc  out  ADDR_W  address of ir_data

Behaviour:
- One clock; reset is asynchronous and active-low (clk, rst_n). All state clears immediately on rst_n low, independent of clk.
- Reset values:
  - pc = mem_addr = RESET_PC
  - ir_valid = 0, ir_data = 0, ir_pc = 0
  - buffer count = 0, inflight = 0
  - mem_we = 0, mem_din = 0
- Memory timing: the address is sampled at edge E; mem_dout is valid during cycle E+1 and is captured at edge E+1.
- Issue at an edge when all hold: !halt, !redirect_valid, and (count + inflight − pop) < 2, where pop = ir_valid & ir_ready.
  - On issue: inflight <= 1, inflight_pc <= pc, pc <= pc + 1.
  - Otherwise: inflight <= 0.
- PC wrap-around: 8'hFF + 1 = 8'h00, with no flag.
- Capture: if inflight is set at an edge, mem_dout and inflight_pc are pushed into the buffer. The occupancy rule guarantees there is never an overflow.
- Buffer: 2-entry FIFO. Head drives ir_data/ir_pc. ir_valid = (count != 0). Simultaneous push and pop keeps count unchanged.
- Handshake: the head is consumed only when ir_valid & ir_ready at an edge. ir_data/ir_pc are stable while ir_valid is high and ir_ready is low.
- Throughput: with ir_ready held high, one instruction per cycle in steady state.
- Latency: the first edge after reset release issues RESET_PC. ir_valid rises after the second edge.
- Redirect (redirect_valid high at an edge):
  - pc <= redirect_pc
  - buffer flushed (count <= 0)
  - inflight <= 0; its response is discarded
  - no issue that edge
  - the target is issued at the next edge (if !halt), so ir_valid returns 2 edges after the redirect edge
- Redirect with a simultaneous pop: the pop counts as a completed transfer, then the flush applies.
- Redirect while halt: the PC still updates; issue resumes when halt falls.
- halt: blocks new issues only. An in-flight word is still captured and buffered words still drain.
- mem_addr always reflects pc, even when not issuing; reads of unissued addresses are ignored.

Decomposition:
- Shared package holds:
  - ADDR_W/DATA_W defaults
  - RESET_PC
  - NOP encoding 16'h0000, used by downstream
- One natural sub-module: fetch_buffer, a 2-entry FIFO with push/pop/flush, count, and head data+pc.
- PC/issue logic stays in instr_fetch_unit.

Test Plan:
- Memory preloaded mem[0..3] = 16'h1111, 2222, 3333, 4444; ir_ready = 1; release rst_n → ir_valid after edge 2, then ir_data 1111, 2222, 3333, 4444 on consecutive cycles with ir_pc 0,1,2,3.
- Backpressure: ir_ready = 0 for 5 cycles after the first valid → ir_data holds 1111 with ir_valid = 1. Count reaches 2 and mem_addr stops advancing (holds 8'h02). Release → 2222, 3333 follow with no loss or duplication.
- Redirect to 8'h80 (mem[80] = 16'hABCD) mid-stream → no words from the old stream appear after the redirect edge. ir_valid is 0 for 2 cycles, then ir_data = ABCD, ir_pc = 8'h80.
- Wrap-around: redirect to 8'hFE, mem[FE] = 16'hFEFE, mem[FF] = 16'hFFFF, mem[00] = 16'h1111 → ir_pc sequence FE, FF, 00.
- halt for 3 cycles during streaming → at most 2 buffered or in-flight words delivered, then ir_valid = 0. After halt falls, delivery resumes at the next sequential pc.
- Assert rst_n low asynchronously mid-stream with a full buffer → ir_valid = 0 and mem_addr = 8'h00 immediately, without a clock edge. Restart matches scenario 1.

Source files
------------

// File: rtl/instr_fetch_unit_pkg.sv
// Shared defaults for the RISC16bit fetch stage and its consumers.
package instr_fetch_unit_pkg;

  localparam int DEF_ADDR_W = 8;
  localparam int DEF_DATA_W = 16;
  localparam logic [DEF_ADDR_W-1:0] DEF_RESET_PC = 8'h00;

  // Decode treats an all-zero word as a bubble.
  localparam logic [DEF_DATA_W-1:0] NOP = 16'h0000;

endpackage

// File: rtl/fetch_buffer.sv
// Two-entry instruction FIFO between the memory response and the decode handshake.
module fetch_buffer #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              push,
  input  logic [DATA_W-1:0] push_data,
  input  logic [ADDR_W-1:0] push_pc,
  input  logic              pop,
  input  logic              flush,
  output logic [1:0]        count,
  output logic [DATA_W-1:0] head_data,
  output logic [ADDR_W-1:0] head_pc
);

  logic [DATA_W-1:0] data_q [2];
  logic [ADDR_W-1:0] pc_q   [2];
  logic              rd_ptr;
  logic              wr_ptr;

  // Flush wins over any push/pop on the same edge; entry contents are left stale.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 2; i++) begin
        data_q[i] <= '0;
        pc_q[i]   <= '0;
      end
      rd_ptr <= 1'b0;
      wr_ptr <= 1'b0;
      count  <= 2'd0;
    end else if (flush) begin
      rd_ptr <= 1'b0;
      wr_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (push) begin
        data_q[wr_ptr] <= push_data;
        pc_q[wr_ptr]   <= push_pc;
        wr_ptr         <= ~wr_ptr;
      end
      if (pop) begin
        rd_ptr <= ~rd_ptr;
      end
      count <= count + 2'(push) - 2'(pop);
    end
  end

  assign head_data = data_q[rd_ptr];
  assign head_pc   = pc_q[rd_ptr];

endmodule

// File: rtl/instr_fetch_unit.sv
// Fetch stage: drives Memory256x16 reads and feeds decode through a 2-entry buffer.
module instr_fetch_unit
  import instr_fetch_unit_pkg::*;
#(
  parameter int                ADDR_W   = DEF_ADDR_W,
  parameter int                DATA_W   = DEF_DATA_W,
  parameter logic [ADDR_W-1:0] RESET_PC = DEF_RESET_PC
) (
  input  logic              clk,
  input  logic              rst_n,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_we,
  output logic [DATA_W-1:0] mem_din,
  input  logic [DATA_W-1:0] mem_dout,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_pc,
  input  logic              halt,
  output logic              ir_valid,
  input  logic              ir_ready,
  output logic [DATA_W-1:0] ir_data,
  output logic [ADDR_W-1:0] ir_pc
);

  logic [ADDR_W-1:0] pc;
  logic [ADDR_W-1:0] inflight_pc;
  logic              inflight;
  logic [1:0]        count;
  logic [2:0]        occupancy;
  logic              pop;
  logic              push;
  logic              issue;

  assign ir_valid = (count != 2'd0);
  assign pop      = ir_valid & ir_ready;

  // Buffered plus in-flight words after this edge's pop must leave room for a new read.
  assign occupancy = {1'b0, count} + {2'b00, inflight} - {2'b00, pop};
  assign issue     = !halt && !redirect_valid && (occupancy < 3'd2);
  assign push      = inflight && !redirect_valid;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc          <= RESET_PC;
      inflight    <= 1'b0;
      inflight_pc <= '0;
    end else if (redirect_valid) begin
      pc       <= redirect_pc;
      inflight <= 1'b0;
    end else begin
      inflight <= issue;
      if (issue) begin
        inflight_pc <= pc;
        pc          <= pc + ADDR_W'(1);
      end
    end
  end

  assign mem_addr = pc;
  assign mem_we   = 1'b0;
  assign mem_din  = '0;

  fetch_buffer #(
    .ADDR_W(ADDR_W),
    .DATA_W(DATA_W)
  ) u_fetch_buffer (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (push),
    .push_data (mem_dout),
    .push_pc   (inflight_pc),
    .pop       (pop),
    .flush     (redirect_valid),
    .count     (count),
    .head_data (ir_data),
    .head_pc   (ir_pc)
  );

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Randomized bench for instr_fetch_unit with a queue-level reference model and directed anchors.
module tb_instr_fetch_unit;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [7:0]  mem_addr;
  logic        mem_we;
  logic [15:0] mem_din;
  logic [15:0] mem_dout = 16'h0000;
  logic        redirect_valid = 1'b0;
  logic [7:0]  redirect_pc = 8'h00;
  logic        halt = 1'b0;
  logic        ir_valid;
  logic        ir_ready = 1'b1;
  logic [15:0] ir_data;
  logic [7:0]  ir_pc;

  int numChecks = 0;
  int numFails  = 0;

  always #5 clk = ~clk;

  instr_fetch_unit #(
    .ADDR_W   (8),
    .DATA_W   (16),
    .RESET_PC (8'h00)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .mem_addr       (mem_addr),
    .mem_we         (mem_we),
    .mem_din        (mem_din),
    .mem_dout       (mem_dout),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .halt           (halt),
    .ir_valid       (ir_valid),
    .ir_ready       (ir_ready),
    .ir_data        (ir_data),
    .ir_pc          (ir_pc)
  );

  // Memory256x16 stand-in: one-cycle synchronous read.
  logic [15:0] mem [256];
  always @(posedge clk) mem_dout <= mem[mem_addr];

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    numChecks++;
    if (actual !== expected) begin
      numFails++;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, actual, expected, $time);
    end
  endtask

  // Reference: fetch pc, one pending read, and a queue of words the decoder will see in order.
  typedef struct {
    logic [7:0]  pc;
    logic [15:0] data;
  } item_t;

  item_t      mq[$];
  logic [7:0] mPc = 8'h00;
  logic [7:0] mIfPc = 8'h00;
  bit         mInflight = 1'b0;
  int         mCnt;
  bit         mPop;
  bit         mIssue;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mq.delete();
      mPc       = 8'h00;
      mIfPc     = 8'h00;
      mInflight = 1'b0;
    end else begin
      mCnt = mq.size();
      mPop = (mCnt != 0) && ir_ready;
      if (mPop) void'(mq.pop_front());
      if (redirect_valid) begin
        mq.delete();
        mInflight = 1'b0;
        mPc       = redirect_pc;
      end else begin
        mIssue = !halt && ((mCnt + int'(mInflight) - int'(mPop)) < 2);
        if (mInflight) mq.push_back('{mIfPc, mem[mIfPc]});
        if (mIssue) begin
          mIfPc = mPc;
          mPc   = mPc + 8'd1;
        end
        mInflight = mIssue;
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      checkOutput("model ir_valid", 32'(ir_valid), 32'(mq.size() != 0));
      checkOutput("model mem_addr", 32'(mem_addr), 32'(mPc));
      checkOutput("model mem_we/din", 32'({mem_we, mem_din}), 32'h0);
      if (mq.size() != 0) begin
        checkOutput("model ir_data", 32'(ir_data), 32'(mq[0].data));
        checkOutput("model ir_pc", 32'(ir_pc), 32'(mq[0].pc));
      end
    end
  end

  task automatic applyStimulus(input bit rdy, input bit hlt, input bit rv, input logic [7:0] rpc);
    ir_ready       = rdy;
    halt           = hlt;
    redirect_valid = rv;
    redirect_pc    = rpc;
  endtask

  task automatic stepCycle();
    @(posedge clk);
    #1;
  endtask

  task automatic expectHead(input string name, input logic [15:0] data, input logic [7:0] pc);
    checkOutput({name, " valid"}, 32'(ir_valid), 32'h1);
    checkOutput({name, " data"}, 32'(ir_data), 32'(data));
    checkOutput({name, " pc"}, 32'(ir_pc), 32'(pc));
  endtask

  task automatic doReset();
    rst_n = 1'b0;
    stepCycle();
    rst_n = 1'b1;
  endtask

  task automatic runStartup();
    stepCycle();
    checkOutput("startup edge1 valid", 32'(ir_valid), 32'h0);
    checkOutput("startup edge1 addr", 32'(mem_addr), 32'h01);
    stepCycle();
    expectHead("startup w0", 16'h1111, 8'h00);
    stepCycle();
    expectHead("startup w1", 16'h2222, 8'h01);
    stepCycle();
    expectHead("startup w2", 16'h3333, 8'h02);
    stepCycle();
    expectHead("startup w3", 16'h4444, 8'h03);
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 16'($urandom);
    mem[8'h00] = 16'h1111;
    mem[8'h01] = 16'h2222;
    mem[8'h02] = 16'h3333;
    mem[8'h03] = 16'h4444;
    mem[8'h80] = 16'hABCD;
    mem[8'hFE] = 16'hFEFE;
    mem[8'hFF] = 16'hFFFF;

    applyStimulus(1'b1, 1'b0, 1'b0, 8'h00);
    #2;
    checkOutput("reset ir_valid", 32'(ir_valid), 32'h0);
    checkOutput("reset mem_addr", 32'(mem_addr), 32'h00);
    checkOutput("reset ir_data", 32'(ir_data), 32'h0);
    checkOutput("reset ir_pc", 32'(ir_pc), 32'h0);
    stepCycle();
    stepCycle();
    rst_n = 1'b1;
    runStartup();

    $display("[TB] backpressure");
    doReset();
    stepCycle();
    stepCycle();
    expectHead("bp first", 16'h1111, 8'h00);
    applyStimulus(1'b0, 1'b0, 1'b0, 8'h00);
    for (int i = 0; i < 5; i++) begin
      stepCycle();
      expectHead("bp hold", 16'h1111, 8'h00);
      checkOutput("bp mem_addr", 32'(mem_addr), 32'h02);
    end
    applyStimulus(1'b1, 1'b0, 1'b0, 8'h00);
    stepCycle();
    expectHead("bp resume w1", 16'h2222, 8'h01);
    stepCycle();
    expectHead("bp resume w2", 16'h3333, 8'h02);

    $display("[TB] redirect to 80");
    applyStimulus(1'b1, 1'b0, 1'b1, 8'h80);
    stepCycle();
    checkOutput("redir gap1", 32'(ir_valid), 32'h0);
    applyStimulus(1'b1, 1'b0, 1'b0, 8'h00);
    stepCycle();
    checkOutput("redir gap2", 32'(ir_valid), 32'h0);
    checkOutput("redir mem_addr", 32'(mem_addr), 32'h81);
    stepCycle();
    expectHead("redir target", 16'hABCD, 8'h80);

    $display("[TB] wrap-around");
    applyStimulus(1'b1, 1'b0, 1'b1, 8'hFE);
    stepCycle();
    checkOutput("wrap gap1", 32'(ir_valid), 32'h0);
    applyStimulus(1'b1, 1'b0, 1'b0, 8'h00);
    stepCycle();
    checkOutput("wrap gap2", 32'(ir_valid), 32'h0);
    stepCycle();
    expectHead("wrap FE", 16'hFEFE, 8'hFE);
    stepCycle();
    expectHead("wrap FF", 16'hFFFF, 8'hFF);
    stepCycle();
    expectHead("wrap 00", 16'h1111, 8'h00);

    $display("[TB] halt");
    applyStimulus(1'b1, 1'b1, 1'b0, 8'h00);
    stepCycle();
    expectHead("halt drain", 16'h2222, 8'h01);
    stepCycle();
    checkOutput("halt empty1", 32'(ir_valid), 32'h0);
    stepCycle();
    checkOutput("halt empty2", 32'(ir_valid), 32'h0);
    applyStimulus(1'b1, 1'b0, 1'b0, 8'h00);
    stepCycle();
    checkOutput("halt restart gap", 32'(ir_valid), 32'h0);
    checkOutput("halt restart addr", 32'(mem_addr), 32'h03);
    stepCycle();
    expectHead("halt resume", 16'h3333, 8'h02);

    $display("[TB] async reset with full buffer");
    applyStimulus(1'b0, 1'b0, 1'b0, 8'h00);
    stepCycle();
    stepCycle();
    checkOutput("full before reset", 32'(ir_valid), 32'h1);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("async rst ir_valid", 32'(ir_valid), 32'h0);
    checkOutput("async rst mem_addr", 32'(mem_addr), 32'h00);
    checkOutput("async rst ir_data", 32'(ir_data), 32'h0);
    applyStimulus(1'b1, 1'b0, 1'b0, 8'h00);
    stepCycle();
    rst_n = 1'b1;
    runStartup();

    $display("[TB] random traffic");
    for (int i = 0; i < 3000; i++) begin
      applyStimulus(bit'($urandom_range(0, 3) != 0), bit'($urandom_range(0, 7) == 0),
                    bit'($urandom_range(0, 15) == 0), 8'($urandom));
      stepCycle();
    end
    applyStimulus(1'b1, 1'b0, 1'b0, 8'h00);
    repeat (5) stepCycle();

    $display("End of test - %0d assertions evaluated, %0d failures", numChecks, numFails);
    $finish;
  end

endmodule
